// File: rtl/regfile_read_arbiter.sv
// Round-robin arbiter sharing one register-file read mux among four requesters.
// One outstanding read at a time: accept, drive mux select, capture word, hold response.
module regfile_read_arbiter #(
    parameter int WIDTH = 20,
    parameter int ADDRW = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [3:0]         i_req_valid,
    input  logic [4*ADDRW-1:0] i_req_addr,
    output logic [3:0]         o_req_ready,
    output logic [ADDRW-1:0]   o_mux_addr,
    input  logic [WIDTH-1:0]   i_mux_data,
    output logic [3:0]         o_rsp_valid,
    output logic [WIDTH-1:0]   o_rsp_data,
    input  logic [3:0]         i_rsp_ready,
    output logic               o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_READ = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t             r_state;
    logic [1:0]         r_ptr;
    logic [1:0]         r_gid;
    logic [ADDRW-1:0]   r_mux_addr;
    logic [WIDTH-1:0]   r_rsp_data;
    logic [3:0]         r_rsp_valid;

    logic               w_any;
    logic [1:0]         w_gidx;
    logic [1:0]         w_idx;
    logic [ADDRW-1:0]   w_sel_addr;

    // Rotating priority scan: first pending requester at or after r_ptr wins.
    always_comb begin
        w_any  = 1'b0;
        w_gidx = 2'd0;
        w_idx  = 2'd0;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + k[1:0];
            if (!w_any && i_req_valid[w_idx]) begin
                w_any  = 1'b1;
                w_gidx = w_idx;
            end
        end
    end

    assign w_sel_addr = i_req_addr[w_gidx*ADDRW +: ADDRW];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_ready
            assign o_req_ready[gi] = i_rst_n && (r_state == S_IDLE) && w_any
                                     && (w_gidx == 2'(gi));
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_ptr       <= 2'd0;
            r_gid       <= 2'd0;
            r_mux_addr  <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_mux_addr <= w_sel_addr;
                        r_gid      <= w_gidx;
                        r_state    <= S_READ;
                    end
                end
                S_READ: begin
                    r_rsp_data  <= i_mux_data;
                    r_rsp_valid <= 4'b0001 << r_gid;
                    r_state     <= S_RESP;
                end
                S_RESP: begin
                    // Pointer moves on completion so the served requester drops to last.
                    if (i_rsp_ready[r_gid]) begin
                        r_rsp_valid <= 4'd0;
                        r_ptr       <= r_gid + 2'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_mux_addr  = r_mux_addr;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_data  = r_rsp_data;
    assign o_busy      = (r_state != S_IDLE);

endmodule
